// File: rtl/sysid_access_arbiter.sv
// Two-master Avalon-MM read arbiter in front of a shared combinational system-ID slave.
// Round-robin on ties, 3-cycle read turnaround, sticky ID-mismatch flag, saturating counters.
module sysid_access_arbiter #(
  parameter logic [31:0] EXPECTED_ID = 32'h6685E85E,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             m0_read,
  input  logic             m1_read,
  input  logic             m0_address,
  input  logic             m1_address,
  output logic             m0_waitrequest,
  output logic             m1_waitrequest,
  output logic             m0_readdatavalid,
  output logic             m1_readdatavalid,
  output logic [31:0]      m0_readdata,
  output logic [31:0]      m1_readdata,
  output logic             s_address,
  input  logic [31:0]      s_readdata,
  output logic             id_mismatch,
  output logic [CNT_W-1:0] m0_count,
  output logic [CNT_W-1:0] m1_count
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             win_q, win_d;
  logic             addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic req_any;
  logic pick_m1;
  logic in_idle;

  // Master 1 wins when it is the only requester, or on a tie when master 0 was granted last.
  assign req_any = m0_read | m1_read;
  assign pick_m1 = m1_read & (~m0_read | ~last_grant_q);
  assign in_idle = (state_q == IDLE);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    win_d        = win_q;
    addr_d       = addr_q;
    data_d       = data_q;
    mismatch_d   = mismatch_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    case (state_q)
      IDLE: begin
        if (req_any) begin
          win_d        = pick_m1;
          last_grant_d = pick_m1;
          addr_d       = pick_m1 ? m1_address : m0_address;
          state_d      = FETCH;
          if (pick_m1) begin
            if (cnt1_q != '1) cnt1_d = cnt1_q + CNT_W'(1);
          end else begin
            if (cnt0_q != '1) cnt0_d = cnt0_q + CNT_W'(1);
          end
        end
      end
      FETCH: begin
        data_d = s_readdata;
        if (!addr_q && (s_readdata != EXPECTED_ID)) mismatch_d = 1'b1;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      win_q        <= 1'b0;
      addr_q       <= 1'b0;
      data_q       <= 32'h0;
      mismatch_q   <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      win_q        <= win_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      mismatch_q   <= mismatch_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  // Stall everyone while in reset or busy; in IDLE only the loser of a live request stalls.
  assign m0_waitrequest   = ~reset_n | ~in_idle | (req_any & pick_m1);
  assign m1_waitrequest   = ~reset_n | ~in_idle | (req_any & ~pick_m1);
  assign m0_readdatavalid = (state_q == RESP) & ~win_q;
  assign m1_readdatavalid = (state_q == RESP) & win_q;
  assign m0_readdata      = data_q;
  assign m1_readdata      = data_q;
  assign s_address        = addr_q;
  assign id_mismatch      = mismatch_q;
  assign m0_count         = cnt0_q;
  assign m1_count         = cnt1_q;

endmodule

// File: tb/tb_sysid_access_arbiter.sv
// Directed bench for sysid_access_arbiter: stimulus pushes expected responses into a queue,
// a negedge monitor pops and checks them whenever a readdatavalid appears.
module tb_sysid_access_arbiter;

  localparam logic [31:0] ID = 32'h6685E85E;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        m0_read = 1'b0, m1_read = 1'b0;
  logic        m0_address = 1'b0, m1_address = 1'b0;
  logic        m0_waitrequest, m1_waitrequest;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata;
  logic        s_address;
  logic [31:0] s_readdata;
  logic        id_mismatch;
  logic [15:0] m0_count, m1_count;

  // Saturation instance shares the master inputs.
  logic        sat_m0_wr, sat_m1_wr, sat_m0_v, sat_m1_v, sat_s_addr, sat_mm;
  logic [31:0] sat_m0_rd, sat_m1_rd, sat_s_rd;
  logic [1:0]  sat_m0_count, sat_m1_count;

  logic [31:0] mem0 = ID;
  logic [31:0] mem1 = 32'h0;
  assign s_readdata = s_address  ? mem1 : mem0;
  assign sat_s_rd   = sat_s_addr ? mem1 : mem0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic        m;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q[$];
  int   acc_q[$];

  sysid_access_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .m0_read(m0_read), .m1_read(m1_read),
    .m0_address(m0_address), .m1_address(m1_address),
    .m0_waitrequest(m0_waitrequest), .m1_waitrequest(m1_waitrequest),
    .m0_readdatavalid(m0_readdatavalid), .m1_readdatavalid(m1_readdatavalid),
    .m0_readdata(m0_readdata), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_readdata(s_readdata),
    .id_mismatch(id_mismatch), .m0_count(m0_count), .m1_count(m1_count)
  );

  sysid_access_arbiter #(.EXPECTED_ID(ID), .CNT_W(2)) u_sat (
    .clock(clock), .reset_n(reset_n),
    .m0_read(m0_read), .m1_read(m1_read),
    .m0_address(m0_address), .m1_address(m1_address),
    .m0_waitrequest(sat_m0_wr), .m1_waitrequest(sat_m1_wr),
    .m0_readdatavalid(sat_m0_v), .m1_readdatavalid(sat_m1_v),
    .m0_readdata(sat_m0_rd), .m1_readdata(sat_m1_rd),
    .s_address(sat_s_addr), .s_readdata(sat_s_rd),
    .id_mismatch(sat_mm), .m0_count(sat_m0_count), .m1_count(sat_m1_count)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      acc_q.delete();
    end else begin
      if (m0_read && !m0_waitrequest && m1_read && !m1_waitrequest)
        chk("single_grant", 32'd2, 32'd1);
      if ((m0_read && !m0_waitrequest) || (m1_read && !m1_waitrequest))
        acc_q.push_back(cyc);
      if (m0_readdatavalid || m1_readdatavalid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("valid_master", {30'd0, m1_readdatavalid, m0_readdatavalid},
              e.m ? 32'd2 : 32'd1);
          chk("m0_readdata", m0_readdata, e.data);
          chk("m1_readdata", m1_readdata, e.data);
          if (acc_q.size() == 0) chk("latency_no_accept", 32'd1, 32'd0);
          else chk("latency", cyc - acc_q.pop_front(), 32'd2);
        end
      end
    end
  end

  // Raise read, wait for acceptance (bounded), then drop it; returns early in FETCH.
  task automatic issue(input bit m, input bit a);
    bit ok = 1'b0;
    @(posedge clock); #1;
    if (m) begin m1_read = 1'b1; m1_address = a; end
    else   begin m0_read = 1'b1; m0_address = a; end
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clock);
      if (m ? !m1_waitrequest : !m0_waitrequest) ok = 1'b1;
    end
    chk("accepted", {31'd0, ok}, 32'd1);
    @(posedge clock); #1;
    m0_read = 1'b0;
    m1_read = 1'b0;
  endtask

  task automatic do_read(input bit m, input bit a, input logic [31:0] data);
    exp_t e;
    e.m = m;
    e.data = data;
    exp_q.push_back(e);
    issue(m, a);
    @(negedge clock);
    chk("s_address_fetch", {31'd0, s_address}, {31'd0, a});
    chk("wait_fetch", {30'd0, m1_waitrequest, m0_waitrequest}, 32'd3);
    @(negedge clock);
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m0_read = 1'b0;
    m1_read = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    int sat_exp[5] = '{1, 2, 3, 3, 3};
    // Reset state
    #12;
    chk("rst_wait", {30'd0, m1_waitrequest, m0_waitrequest}, 32'd3);
    chk("rst_valid", {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
    chk("rst_s_address", {31'd0, s_address}, 32'd0);
    chk("rst_data", m0_readdata, 32'd0);
    chk("rst_mismatch", {31'd0, id_mismatch}, 32'd0);
    chk("rst_counts", {m1_count, m0_count}, 32'd0);
    @(posedge clock); #1 reset_n = 1'b1;
    @(negedge clock);
    chk("idle_no_req_wait", {30'd0, m1_waitrequest, m0_waitrequest}, 32'd0);

    // Single good read
    do_read(1'b0, 1'b0, ID);
    chk("single_mismatch", {31'd0, id_mismatch}, 32'd0);
    chk("single_m0_count", {16'd0, m0_count}, 32'd1);

    // Address-1 read leaves flag alone
    mem1 = 32'h12345678;
    do_read(1'b0, 1'b1, 32'h12345678);
    chk("addr1_mismatch", {31'd0, id_mismatch}, 32'd0);

    // Mismatch via master 1, then sticky through a correct read
    mem0 = 32'h0;
    do_read(1'b1, 1'b0, 32'h0);
    chk("mismatch_set", {31'd0, id_mismatch}, 32'd1);
    chk("m1_count", {16'd0, m1_count}, 32'd1);
    mem0 = ID;
    do_read(1'b0, 1'b0, ID);
    chk("mismatch_sticky", {31'd0, id_mismatch}, 32'd1);

    // Tie from reset: m0, m1, m0, m1
    do_reset();
    chk("reset_clears_mismatch", {31'd0, id_mismatch}, 32'd0);
    mem1 = 32'hA5A5_0001;
    for (int i = 0; i < 4; i++) begin
      exp_t e;
      e.m = i[0];
      e.data = ID;
      exp_q.push_back(e);
    end
    @(posedge clock); #1;
    m0_read = 1'b1; m0_address = 1'b0;
    m1_read = 1'b1; m1_address = 1'b0;
    repeat (10) @(posedge clock);
    #1 m0_read = 1'b0; m1_read = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("tie_counts", {m1_count, m0_count}, {16'd2, 16'd2});

    // Reset during FETCH aborts the transaction
    issue(1'b0, 1'b0);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("midrst_wait", {30'd0, m1_waitrequest, m0_waitrequest}, 32'd3);
    chk("midrst_valid", {30'd0, m1_readdatavalid, m0_readdatavalid}, 32'd0);
    chk("midrst_counts", {m1_count, m0_count}, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    do_read(1'b0, 1'b0, ID);
    chk("midrst_after_count", {16'd0, m0_count}, 32'd1);

    // Saturation on the 2-bit instance
    do_reset();
    for (int i = 0; i < 5; i++) begin
      do_read(1'b0, 1'b0, ID);
      chk("sat_m0_count", {30'd0, sat_m0_count}, sat_exp[i]);
    end
    chk("wide_m0_count", {16'd0, m0_count}, 32'd5);

    repeat (3) @(posedge clock);
    chk("exp_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
